// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: shared types and constants for the pipeline controller.
package pipeline_ctrl_pkg;
    typedef enum logic [1:0] {
        ST_RUN           = 2'd0,
        ST_REDIRECT_WAIT = 2'd1,
        ST_HALT          = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SEL_HOLD = 2'd0,
        SEL_STEP = 2'd1,
        SEL_JUMP = 2'd2,
        SEL_PEND = 2'd3
    } pc_sel_t;

    localparam logic [31:0] INST_NOP     = 32'h0000_0013;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEF_PC_STEP  = 32'd4;
    localparam logic [31:0] DEF_TRAP_PC  = 32'h0000_0100;

    function automatic logic misaligned(input logic [31:0] a);
        return a[1:0] != 2'b00;
    endfunction
endpackage

// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if: EX-stage requests, fetch handshake and pipeline controls.
// misalign_err exists only when MISALIGN_TRAP_EN is defined.
interface pipeline_ctrl_if;
    logic        jump_en;
    logic [31:0] jump_addr;
    logic        hold_en;
    logic        fetch_ack;
    logic        halt_req;
    logic [31:0] pc;
    logic        fetch_req;
    logic        flush_if_id;
    logic        flush_id_ex;
    logic        stall_pc;
    logic        stall_if_id;
    logic        stall_id_ex;
    logic        halted;
`ifdef MISALIGN_TRAP_EN
    logic        misalign_err;
`endif

    modport master (
        input  jump_en, jump_addr, hold_en, fetch_ack, halt_req,
        output pc, fetch_req, flush_if_id, flush_id_ex, stall_pc, stall_if_id, stall_id_ex, halted
`ifdef MISALIGN_TRAP_EN
        , output misalign_err
`endif
    );

    modport slave (
        output jump_en, jump_addr, hold_en, fetch_ack, halt_req,
        input  pc, fetch_req, flush_if_id, flush_id_ex, stall_pc, stall_if_id, stall_id_ex, halted
`ifdef MISALIGN_TRAP_EN
        , input misalign_err
`endif
    );
endinterface

// File: rtl/pc_next_sel.sv
// pc_next_sel: combinational next-PC mux (hold, +step, jump target, pending target).
// Under MISALIGN_TRAP_EN misaligned jumps go to TRAP_PC; otherwise low bits are cleared.
module pc_next_sel
    import pipeline_ctrl_pkg::*;
#(
    parameter logic [31:0] PC_STEP = DEF_PC_STEP,
    parameter logic [31:0] TRAP_PC = DEF_TRAP_PC
) (
    input  pc_sel_t     i_sel,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_jump_addr,
    input  logic [31:0] i_pend_addr,
    output logic [31:0] o_jump_tgt,
    output logic [31:0] o_pc_next
);
`ifdef MISALIGN_TRAP_EN
    assign o_jump_tgt = misaligned(i_jump_addr) ? TRAP_PC : i_jump_addr;
`else
    logic w_unused;
    assign w_unused   = ^{TRAP_PC, i_jump_addr[1:0]};
    assign o_jump_tgt = {i_jump_addr[31:2], 2'b00};
`endif
    assign o_pc_next = i_sel == SEL_STEP ? i_pc + PC_STEP :
                       i_sel == SEL_JUMP ? o_jump_tgt :
                       i_sel == SEL_PEND ? i_pend_addr : i_pc;
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: PC sequencer, fetch handshake, redirect-wait and halt FSM for the IF/ID/EX core.
// Optional MISALIGN_TRAP_EN traps misaligned jumps to TRAP_PC and adds sticky misalign_err.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter logic [31:0] PC_STEP  = DEF_PC_STEP,
    parameter logic [31:0] TRAP_PC  = DEF_TRAP_PC
) (
    input logic              clk,
    input logic              rst,
    pipeline_ctrl_if.master  bus
);
    state_t      r_state, w_state_nxt;
    pc_sel_t     w_sel;
    logic [31:0] r_pc, r_pend_addr, r_pc_next_unused, w_pc_next, w_jump_tgt;
    logic        r_halted, w_pend_load;
    logic        w_fetch_req, w_flush_if_id, w_flush_id_ex, w_stall_pc, w_stall_if_id, w_stall_id_ex;

    pc_next_sel #(.PC_STEP(PC_STEP), .TRAP_PC(TRAP_PC)) u_pc_next_sel (
        .i_sel       (w_sel),
        .i_pc        (r_pc),
        .i_jump_addr (bus.jump_addr),
        .i_pend_addr (r_pend_addr),
        .o_jump_tgt  (w_jump_tgt),
        .o_pc_next   (w_pc_next)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_sel         = SEL_HOLD;
        w_pend_load   = 1'b0;
        w_fetch_req   = 1'b0;
        w_flush_if_id = 1'b0;
        w_flush_id_ex = 1'b0;
        w_stall_pc    = 1'b0;
        w_stall_if_id = 1'b0;
        w_stall_id_ex = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (bus.jump_en) begin
                    w_fetch_req   = 1'b1;
                    w_flush_if_id = 1'b1;
                    w_flush_id_ex = 1'b1;
                    w_stall_pc    = !bus.fetch_ack;
                    w_sel         = bus.fetch_ack ? SEL_JUMP : SEL_HOLD;
                    w_pend_load   = !bus.fetch_ack;
                    w_state_nxt   = bus.fetch_ack ? ST_RUN : ST_REDIRECT_WAIT;
                end else if (bus.hold_en) begin
                    w_stall_pc    = 1'b1;
                    w_stall_if_id = 1'b1;
                    w_stall_id_ex = 1'b1;
                end else begin
                    // halt_req drops the request but still honours an ack already in flight
                    w_fetch_req   = !bus.halt_req;
                    w_sel         = bus.fetch_ack ? SEL_STEP : SEL_HOLD;
                    w_stall_pc    = !bus.fetch_ack;
                    w_flush_if_id = !bus.fetch_ack;
                    w_state_nxt   = bus.halt_req ? ST_HALT : ST_RUN;
                end
            end
            ST_REDIRECT_WAIT: begin
                w_fetch_req   = 1'b1;
                w_flush_if_id = 1'b1;
                w_stall_pc    = !bus.fetch_ack;
                w_sel         = bus.fetch_ack ? SEL_PEND : SEL_HOLD;
                w_state_nxt   = bus.fetch_ack ? ST_RUN : ST_REDIRECT_WAIT;
            end
            ST_HALT: begin
                w_stall_pc    = 1'b1;
                w_flush_if_id = 1'b1;
                w_flush_id_ex = bus.jump_en;
                w_sel         = bus.jump_en ? SEL_JUMP : SEL_HOLD;
                w_state_nxt   = bus.halt_req ? ST_HALT : ST_RUN;
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_pc        <= RESET_PC;
            r_pend_addr <= '0;
            r_halted    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_next;
            r_pend_addr <= w_pend_load ? w_jump_tgt : r_pend_addr;
            r_halted    <= w_state_nxt == ST_HALT;
        end
    end

`ifdef MISALIGN_TRAP_EN
    logic r_misalign_err;
    always_ff @(posedge clk) begin
        if (rst) r_misalign_err <= 1'b0;
        else if (bus.jump_en && r_state != ST_REDIRECT_WAIT && misaligned(bus.jump_addr)) r_misalign_err <= 1'b1;
    end
    assign bus.misalign_err = r_misalign_err;
`endif

    assign r_pc_next_unused = '0;
    assign bus.pc          = r_pc;
    assign bus.halted      = r_halted;
    assign bus.fetch_req   = !rst && w_fetch_req;
    assign bus.flush_if_id = !rst && w_flush_if_id;
    assign bus.flush_id_ex = !rst && w_flush_id_ex;
    assign bus.stall_pc    = !rst && w_stall_pc;
    assign bus.stall_if_id = !rst && w_stall_if_id;
    assign bus.stall_id_ex = !rst && w_stall_id_ex;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed plan steps plus random traffic against a behavioural PC/mode model.
module tb_pipeline_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    logic [31:0] m_pc   = 32'h0;
    logic [31:0] m_pend = 32'h0;
    bit          m_wait = 1'b0;
    bit          m_halt = 1'b0;
    bit          m_err  = 1'b0;

    pipeline_ctrl_if bus();
    pipeline_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] jump_target(input logic [31:0] a);
`ifdef MISALIGN_TRAP_EN
        return (a % 4 != 0) ? 32'h100 : a;
`else
        return a & ~32'd3;
`endif
    endfunction

    // outputs as {fetch_req, flush_if_id, flush_id_ex, stall_pc, stall_if_id, stall_id_ex}
    task automatic step(input logic r, input logic je, input logic [31:0] ja,
                        input logic h, input logic a, input logic hr);
        logic [5:0] exp_v, care, obs_v;
        bit         jump_taken;
        rst = r;
        bus.jump_en = je;
        bus.jump_addr = ja;
        bus.hold_en = h;
        bus.fetch_ack = a;
        bus.halt_req = hr;
        #2;
        care = 6'b111111;
        exp_v = 6'b000000;
        if (!r) begin
            if (m_wait) exp_v = {1'b1, 1'b1, 1'b0, !a, 1'b0, 1'b0};
            else if (m_halt) exp_v = {1'b0, 1'b1, je, 1'b1, 1'b0, 1'b0};
            else if (je) begin
                exp_v = 6'b111000;
                care = 6'b111011;
            end else if (h) exp_v = 6'b000111;
            else if (hr) care = 6'b101011;
            else exp_v = {1'b1, !a, 1'b0, !a, 1'b0, 1'b0};
        end
        obs_v = {bus.fetch_req, bus.flush_if_id, bus.flush_id_ex, bus.stall_pc, bus.stall_if_id, bus.stall_id_ex};
        chk("ctrl_outputs", {26'd0, obs_v & care}, {26'd0, exp_v & care});
        @(posedge clk);
        #1;
        jump_taken = 1'b0;
        if (r) begin
            m_pc = 32'h0; m_wait = 1'b0; m_halt = 1'b0; m_err = 1'b0; m_pend = 32'h0;
        end else if (m_wait) begin
            if (a) begin m_pc = m_pend; m_wait = 1'b0; end
        end else if (m_halt) begin
            if (je) begin m_pc = jump_target(ja); jump_taken = 1'b1; end
            if (!hr) m_halt = 1'b0;
        end else if (je) begin
            jump_taken = 1'b1;
            if (a) m_pc = jump_target(ja);
            else begin m_pend = jump_target(ja); m_wait = 1'b1; end
        end else if (!h) begin
            if (a) m_pc = m_pc + 32'd4;
            if (hr) m_halt = 1'b1;
        end
        if (jump_taken && ja % 4 != 0) m_err = 1'b1;
        chk("pc", bus.pc, m_pc);
        chk("halted", {31'd0, bus.halted}, {31'd0, m_halt});
`ifdef MISALIGN_TRAP_EN
        chk("misalign_err", {31'd0, bus.misalign_err}, {31'd0, m_err});
`endif
    endtask

    initial begin
        bus.jump_en = 0; bus.jump_addr = 0; bus.hold_en = 0; bus.fetch_ack = 0; bus.halt_req = 0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) step(1, 0, 32'h0, 0, 1, 0);
        chk("reset_pc", bus.pc, 32'h0);
        rst = 0;
        #1;
        chk("first_fetch_req", {31'd0, bus.fetch_req}, 32'd1);
        for (int i = 1; i <= 4; i++) begin
            step(0, 0, 32'h0, 0, 1, 0);
            chk("seq_pc", bus.pc, 32'(i * 4));
        end
        step(0, 1, 32'h86, 1, 1, 0);
`ifdef MISALIGN_TRAP_EN
        chk("jump_ack_pc", bus.pc, 32'h100);
`else
        chk("jump_ack_pc", bus.pc, 32'h84);
`endif
        step(0, 1, 32'h20, 0, 1, 0);
        step(0, 1, 32'h200, 0, 0, 0);
        chk("redir_wait_pc0", bus.pc, 32'h20);
        step(0, 1, 32'h300, 0, 0, 1);
        chk("redir_wait_pc1", bus.pc, 32'h20);
        step(0, 0, 32'h0, 0, 0, 1);
        chk("redir_wait_pc2", bus.pc, 32'h20);
        step(0, 0, 32'h0, 0, 1, 0);
        chk("redir_done_pc", bus.pc, 32'h200);
        step(0, 1, 32'h40, 0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 32'h0, 1, 1'($urandom), 0);
            chk("hold_pc", bus.pc, 32'h40);
        end
        step(0, 0, 32'h0, 0, 1, 0);
        chk("hold_release_pc", bus.pc, 32'h44);
        step(0, 1, 32'h60, 0, 1, 0);
        step(0, 0, 32'h0, 0, 1, 1);
        chk("halt_pc", bus.pc, 32'h64);
        chk("halted_set", {31'd0, bus.halted}, 32'd1);
        step(0, 0, 32'h0, 0, 0, 1);
        step(0, 0, 32'h0, 0, 0, 0);
        chk("resume_pc", bus.pc, 32'h64);
        #1;
        chk("resume_fetch_req", {31'd0, bus.fetch_req}, 32'd1);
        step(0, 1, 32'hFFFF_FFFC, 0, 1, 0);
        step(0, 0, 32'h0, 0, 1, 0);
        chk("wrap_pc", bus.pc, 32'h0);
`ifdef MISALIGN_TRAP_EN
        step(0, 1, 32'h1002, 0, 1, 0);
        chk("trap_pc", bus.pc, 32'h100);
        chk("trap_err", {31'd0, bus.misalign_err}, 32'd1);
        for (int i = 0; i < 3; i++) step(0, 0, 32'h0, 0, 1, 0);
        chk("trap_err_sticky", {31'd0, bus.misalign_err}, 32'd1);
`endif
        for (int i = 0; i < 2000; i++) begin
            logic [31:0] ja;
            ja = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h0000_0FFC);
            step($urandom_range(0, 63) == 0, $urandom_range(0, 7) == 0, ja,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, 7) < 2);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Pipeline control and PC sequencer for the 3-stage (IF/ID/EX) core. It consumes the jump_en / jump_addr / hold_en requests driven by the execution stage and owns the PC register. It also runs the instruction-fetch request/acknowledge handshake and drives flush/stall controls to the PC, IF/ID and ID/EX pipeline registers. It adds an external halt request and a redirect-while-fetch-pending state machine.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded by reset
PC_STEP, 32'd4, increment per acknowledged sequential fetch
TRAP_PC, 32'h0000_0100, redirect target for misaligned jumps (used only with the optional feature)

Ports:
clk  in  1  core clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
jump_en  in  1  EX-stage redirect request, combinational, valid in the same cycle
jump_addr  in  32  redirect target; sampled only when jump_en=1
hold_en  in  1  EX-stage hold request
fetch_ack  in  1  instruction memory has returned the word for pc this cycle
halt_req  in  1  external/debug halt request, level-sensitive
pc  out  32  registered fetch address
fetch_req  out  1  fetch request for pc (combinational from state and inputs)
flush_if_id  out  1  IF/ID register loads a NOP (32'h0000_0013) at this edge
flush_id_ex  out  1  ID/EX register loads a NOP at this edge
stall_pc  out  1  PC holds (informational; pc update is internal)
stall_if_id  out  1  IF/ID register holds
stall_id_ex  out  1  ID/EX register holds
halted  out  1  registered; 1 while in HALT

Behaviour:
- Reset (rst=1 at edge): pc<=RESET_PC, state<=RUN, pend_addr<=0, halted<=0. While rst=1, all combinational outputs are forced to 0, including fetch_req.
- States: RUN, REDIRECT_WAIT, HALT. Encoding is 2-bit, defined in the package.
- Priority within RUN: jump_en > hold_en > halt_req > fetch stall.
- RUN, no event:
  - fetch_req=1.
  - If fetch_ack=1: pc<=pc+PC_STEP (mod 2^32; 32'hFFFF_FFFC wraps to 0).
  - If fetch_ack=0: stall_pc=1, flush_if_id=1 (bubble), pc holds.
- RUN, jump_en=1 (hold_en ignored):
  - flush_if_id=1 and flush_id_ex=1 in the same cycle.
  - If fetch_ack=1: pc<=jump_addr at the edge; stay in RUN. The acked word is discarded.
  - If fetch_ack=0: pend_addr<=jump_addr; go to REDIRECT_WAIT; pc holds.
  - Redirect penalty is exactly 2 bubbles reaching EX.
- REDIRECT_WAIT:
  - fetch_req=1 for the old pc; flush_if_id=1 every cycle; jump_en and halt_req are ignored.
  - On fetch_ack=1: pc<=pend_addr, go to RUN.
- RUN, hold_en=1 with jump_en=0:
  - fetch_req=0; stall_pc, stall_if_id and stall_id_ex are all 1; no flush; pc holds.
  - The hold may last any number of cycles. Fetch resumes with the same pc the cycle after hold_en falls.
- RUN, halt_req=1 with no jump/hold:
  - fetch_req=0; go to HALT at the edge; halted=1 from the next cycle.
  - If fetch_ack=1 in that cycle, pc<=pc+PC_STEP first.
- HALT:
  - fetch_req=0, stall_pc=1, flush_if_id=1, so the pipeline drains to NOPs.
  - jump_en is honoured, so an instruction still in EX may redirect: pc<=jump_addr, flush_id_ex=1, remain in HALT.
  - When halt_req=0: go to RUN; fetch_req=1 in the next cycle with the current pc.
- A flush and a stall are never both asserted on the same register; flush wins.
- Reset mid-REDIRECT_WAIT or mid-HALT: pending redirect is dropped; pc=RESET_PC.
- No output has a combinational path from pc.

Optional Feature:
MISALIGN_TRAP_EN:
- Defined: a jump with jump_addr[1:0]!=0 redirects to TRAP_PC instead. Port misalign_err (out, 1, sticky registered, cleared only by rst) is added and set at that edge. This applies in every state that honours jump_en.
- Undefined: jump_addr[1:0] are forced to 2'b00 before loading; no misalign_err port.

Decomposition:
- Package pipeline_ctrl_pkg holds:
  - state typedef/localparams: ST_RUN, ST_REDIRECT_WAIT, ST_HALT
  - INST_NOP = 32'h0000_0013
  - default RESET_PC, PC_STEP and TRAP_PC constants
- One sub-module, pc_next_sel: combinational next-PC mux covering hold, +step, jump_addr, pend_addr and trap.
- The FSM and registers stay in pipeline_ctrl.

Test Plan:
- Reset sequence: rst=1 for 3 cycles, release, fetch_ack=1 constant → pc = 0x0, 0x4, 0x8, 0xC on consecutive cycles; fetch_req=1 from the first post-reset cycle.
- Jump with ack: at pc=0x10, jump_en=1, jump_addr=0x86 (misaligned) with MISALIGN_TRAP_EN undefined → flush_if_id=flush_id_ex=1 that cycle; next pc=0x84.
- Jump while fetch pending: at pc=0x20, fetch_ack=0, jump_en=1, jump_addr=0x200 → state REDIRECT_WAIT, pc stays 0x20 for 3 cycles. Ack on the 4th cycle → pc=0x200; flush_if_id=1 throughout.
- Hold: at pc=0x40, hold_en=1 for 4 cycles → fetch_req=0, all three stall outputs =1, pc=0x40. After release, pc=0x44 one cycle after the ack.
- Halt/resume: halt_req=1 at pc=0x60 with ack → halted=1 next cycle, pc=0x64 frozen. halt_req=0 → fetch_req=1 at 0x64 the following cycle.
- With MISALIGN_TRAP_EN: jump_addr=0x1002 → pc=TRAP_PC (0x100), misalign_err=1 and stays 1 until rst.
